// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU with NZCV flags and a chaining accumulator
//
// Purpose: S1 captures a command on the in_valid/in_ready handshake. The datapath
// evaluates the S1 contents, and S2 registers the result and flags whenever S1 advances.
// An internal accumulator (acc) and carry flag (cf) follow every S2 load. Multi-word
// arithmetic can therefore chain through use_acc and ADC without any forwarding.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  command handshake
//   op[2:0]             000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC, 110 SHL, 111 SHR
//   use_acc             replace operand A with the accumulator
//   a, b [WIDTH-1:0]    operands
//   acc_clr             clear acc and cf at the next edge (wins over an S2 load)
//   out_valid, out_ready result handshake
//   result [WIDTH-1:0]  result
//   flags[3:0]          {N, Z, C, V}
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s1_use_acc_q, s1_use_acc_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic [3:0]       s2_flags_q, s2_flags_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cf_q, cf_d;

  logic             accept;
  logic             s2_load;
  logic [WIDTH-1:0] opa;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;

  // S1 may move into S2 when S2 is empty or is being drained this cycle.
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  // Combinational from out_ready only; in_valid never feeds back into in_ready.
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;

  // Datapath on S1 contents. Reading acc_q here gives back-to-back chaining:
  // the previous command loaded acc at the same edge this one entered S1.
  always_comb begin
    opa   = s1_use_acc_q ? acc_q : s1_a_q;
    sum   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (s1_op_q)
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, opa} + {1'b0, s1_b_q}
              + {{WIDTH{1'b0}}, (s1_op_q == OP_ADC) & cf_q};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (opa[WIDTH-1] == s1_b_q[WIDTH-1]) && (alu_r[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (A < B unsigned).
        sum   = {1'b0, opa} - {1'b0, s1_b_q};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (opa[WIDTH-1] != s1_b_q[WIDTH-1]) && (alu_r[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND: alu_r = opa & s1_b_q;
      OP_OR:  alu_r = opa | s1_b_q;
      OP_XOR: alu_r = opa ^ s1_b_q;
      OP_SHL: begin
        alu_r = {opa[WIDTH-2:0], 1'b0};
        alu_c = opa[WIDTH-1];
      end
      OP_SHR: begin
        alu_r = {1'b0, opa[WIDTH-1:1]};
        alu_c = opa[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_use_acc_d = s1_use_acc_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_op_d      = op;
      s1_use_acc_d = use_acc;
      s1_a_d       = a;
      s1_b_d       = b;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_result_d = alu_r;
      s2_flags_d  = {alu_r[WIDTH-1], (alu_r == '0), alu_c, alu_v};
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Clear takes priority over the load so a software clear is never lost.
  always_comb begin
    acc_d = acc_q;
    cf_d  = cf_q;
    if (acc_clr) begin
      acc_d = '0;
      cf_d  = 1'b0;
    end else if (s2_load) begin
      acc_d = alu_r;
      cf_d  = alu_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_use_acc_q <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_flags_q   <= '0;
      acc_q        <= '0;
      cf_q         <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_use_acc_q <= s1_use_acc_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_flags_q   <= s2_flags_d;
      acc_q        <= acc_d;
      cf_q         <= cf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_result_q;
  assign flags     = s2_flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe at WIDTH 8, 16 and 2
module tb_alu_pipe;

  localparam int WD [3] = '{8, 16, 2};

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  op;
  logic        use_acc;
  logic [15:0] a;
  logic [15:0] b;
  logic        acc_clr;
  logic        out_ready;

  logic        rdy8, ov8, rdy16, ov16, rdy2, ov2;
  logic [7:0]  res8;
  logic [15:0] res16;
  logic [1:0]  res2;
  logic [3:0]  fl8, fl16, fl2;

  alu_pipe #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .op(op),
    .use_acc(use_acc), .a(a[7:0]), .b(b[7:0]), .acc_clr(acc_clr),
    .out_valid(ov8), .out_ready(out_ready), .result(res8), .flags(fl8)
  );

  alu_pipe #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16), .op(op),
    .use_acc(use_acc), .a(a), .b(b), .acc_clr(acc_clr),
    .out_valid(ov16), .out_ready(out_ready), .result(res16), .flags(fl16)
  );

  alu_pipe #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .op(op),
    .use_acc(use_acc), .a(a[1:0]), .b(b[1:0]), .acc_clr(acc_clr),
    .out_valid(ov2), .out_ready(out_ready), .result(res2), .flags(fl2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [19:0] q0[$], q1[$], q2[$], log8[$];
  longint      acc_m [3];
  bit          cf_m  [3];
  logic        last_acc;

  typedef struct {
    logic [2:0] op;
    logic       ua;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed values of the operands.
  function automatic logic [19:0] model(input int w, input logic [2:0] o,
                                        input longint av, input longint bv, input bit cin);
    longint m, hi, lo, ua, ub, sa, sb, t, s, rr;
    bit c, v;
    m  = (longint'(1) << w) - 1;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(hi + 1);
    ua = av & m;
    ub = bv & m;
    sa = (ua > hi) ? ua - (m + 1) : ua;
    sb = (ub > hi) ? ub - (m + 1) : ub;
    c = 1'b0; v = 1'b0; t = 0; s = 0;
    case (o)
      3'd0: begin t = ua + ub;       s = sa + sb;       c = (t > m);  v = (s > hi) || (s < lo); end
      3'd1: begin t = ua - ub;       s = sa - sb;       c = (ua < ub); v = (s > hi) || (s < lo); end
      3'd2: t = ua & ub;
      3'd3: t = ua | ub;
      3'd4: t = ua ^ ub;
      3'd5: begin t = ua + ub + cin; s = sa + sb + cin; c = (t > m);  v = (s > hi) || (s < lo); end
      3'd6: begin t = ua * 2;        c = (ua > hi); end
      default: begin t = ua / 2;     c = (ua % 2) == 1; end
    endcase
    rr = t & m;
    return {(rr > hi), (rr == 0), c, v, 16'(rr)};
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [19:0] qfront(input int d);
    case (d)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int d);
    logic [19:0] x;
    case (d)
      0: x = q0.pop_front();
      1: x = q1.pop_front();
      default: x = q2.pop_front();
    endcase
  endtask

  task automatic qpush(input int d, input logic [19:0] x);
    case (d)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin
      acc_m[i] = 0;
      cf_m[i]  = 1'b0;
    end
  endtask

  // Bookkeeping for one DUT just before the rising edge: the pipeline holds n commands;
  // with both stages full it can only take a new one if the result drains.
  task automatic dut_step(input int d, input logic rdy, input logic ov,
                          input logic [15:0] res, input logic [3:0] fl);
    logic [19:0] e, got;
    longint av;
    int n;
    got = {fl, res};
    n = qsize(d);
    chk($sformatf("in_ready_w%0d", WD[d]), 32'(rdy), 32'((n < 2) || out_ready));
    if (ov === 1'b1) begin
      if (n == 0) begin
        chk($sformatf("spurious_out_valid_w%0d", WD[d]), 32'(ov), 32'd0);
      end else begin
        e = qfront(d);
        chk($sformatf("result_flags_w%0d", WD[d]), 32'(got), 32'(e));
        if (out_ready) begin
          qpop(d);
          if (d == 0) log8.push_back(got);
        end
      end
    end
    if (acc_clr) begin
      acc_m[d] = 0;
      cf_m[d]  = 1'b0;
    end
    if (in_valid && rdy) begin
      av = use_acc ? acc_m[d] : longint'(a);
      e = model(WD[d], op, av, longint'(b), cf_m[d]);
      acc_m[d] = longint'(e[15:0]);
      cf_m[d]  = e[17];
      qpush(d, e);
    end
  endtask

  task automatic cycle();
    #1;
    last_acc = in_valid && rdy8;
    dut_step(0, rdy8, ov8, {8'd0, res8}, fl8);
    dut_step(1, rdy16, ov16, res16, fl16);
    dut_step(2, rdy2, ov2, {14'd0, res2}, fl2);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_cmd();
    op      = 3'($urandom_range(0, 7));
    use_acc = 1'($urandom_range(0, 1));
    a       = 16'($urandom);
    b       = 16'($urandom);
  endtask

  task automatic chain(input logic clr, input logic [19:0] exp2);
    log8.delete();
    out_ready = 1'b1;
    op = 3'd0; use_acc = 1'b0; a = 16'h00FF; b = 16'h0001; in_valid = 1'b1;
    cycle();
    op = 3'd5; use_acc = 1'b1; a = 16'h5A5A; b = 16'h0000; acc_clr = clr;
    cycle();
    in_valid = 1'b0; acc_clr = 1'b0;
    repeat (3) cycle();
    chk("chain_count", 32'(log8.size()), 32'd2);
    if (log8.size() == 2) begin
      chk("chain_first", 32'(log8[0]), 32'h6_0000);
      chk("chain_second", 32'(log8[1]), 32'(exp2));
    end
  endtask

  initial begin
    int sent;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; use_acc = 1'b0; a = '0; b = '0;
    acc_clr = 1'b0; out_ready = 1'b1; last_acc = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid_w8", 32'(ov8), 32'd0);
    chk("rst_out_valid_w16", 32'(ov16), 32'd0);
    chk("rst_out_valid_w2", 32'(ov2), 32'd0);
    chk("rst_in_ready_w8", 32'(rdy8), 32'd1);
    chk("rst_in_ready_w16", 32'(rdy16), 32'd1);
    chk("rst_in_ready_w2", 32'(rdy2), 32'd1);
    chk("rst_result_w8", 32'(res8), 32'd0);
    chk("rst_result_w16", 32'(res16), 32'd0);
    chk("rst_result_w2", 32'(res2), 32'd0);
    chk("rst_flags_w8", 32'(fl8), 32'd0);
    chk("rst_flags_w16", 32'(fl16), 32'd0);
    chk("rst_flags_w2", 32'(fl2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, one command at a time; acc/cf carry over between rows.
    tbl[0]  = '{3'd0, 1'b0, 8'hF0, 8'h20, 8'h10, 4'b0010};
    tbl[1]  = '{3'd3, 1'b1, 8'hFF, 8'h00, 8'h10, 4'b0000};
    tbl[2]  = '{3'd1, 1'b0, 8'h05, 8'h07, 8'hFE, 4'b1010};
    tbl[3]  = '{3'd1, 1'b0, 8'h80, 8'h01, 8'h7F, 4'b0001};
    tbl[4]  = '{3'd6, 1'b0, 8'h81, 8'h33, 8'h02, 4'b0010};
    tbl[5]  = '{3'd7, 1'b0, 8'h01, 8'hC4, 8'h00, 4'b0110};
    tbl[6]  = '{3'd4, 1'b0, 8'hAA, 8'hFF, 8'h55, 4'b0000};
    tbl[7]  = '{3'd2, 1'b0, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    tbl[8]  = '{3'd0, 1'b0, 8'h7F, 8'h01, 8'h80, 4'b1001};
    tbl[9]  = '{3'd0, 1'b0, 8'hFF, 8'h01, 8'h00, 4'b0110};
    tbl[10] = '{3'd5, 1'b0, 8'h10, 8'h20, 8'h31, 4'b0000};
    tbl[11] = '{3'd5, 1'b0, 8'h7F, 8'h7F, 8'hFE, 4'b1001};
    tbl[12] = '{3'd1, 1'b0, 8'h00, 8'h00, 8'h00, 4'b0100};
    tbl[13] = '{3'd5, 1'b1, 8'hEE, 8'h01, 8'h01, 4'b0000};
    for (int i = 0; i < 14; i++) begin
      op = tbl[i].op; use_acc = tbl[i].ua;
      a = {8'($urandom), tbl[i].a};
      b = {8'($urandom), tbl[i].b};
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_not_early", i), 32'(ov8), 32'd0);
      cycle();
      chk($sformatf("tbl%0d_out_valid", i), 32'(ov8), 32'd1);
      chk($sformatf("tbl%0d_result", i), 32'(res8), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_flags", i), 32'(fl8), 32'(tbl[i].f));
      cycle();
    end

    chain(1'b0, 20'h0_0001);
    chain(1'b1, 20'h4_0000);

    // Backpressure: out_ready low for five cycles while commands keep coming.
    log8.delete();
    out_ready = 1'b0; in_valid = 1'b0; sent = 0;
    for (int cyc = 0; cyc < 60 && log8.size() < 6; cyc++) begin
      if (cyc == 5) begin
        chk("bp_accepts_during_stall", 32'(sent), 32'd2);
        chk("bp_in_ready_low", 32'(rdy8), 32'd0);
        out_ready = 1'b1;
      end
      if (!in_valid && sent < 6) begin
        in_valid = 1'b1;
        rand_cmd();
      end
      cycle();
      if (last_acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("bp_result_count", 32'(log8.size()), 32'd6);

    // Random traffic with random backpressure on all three widths.
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        rand_cmd();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk("drain_empty_w8", 32'(q0.size()), 32'd0);
    chk("drain_empty_w16", 32'(q1.size()), 32'd0);
    chk("drain_empty_w2", 32'(q2.size()), 32'd0);

    // Reset with both stages occupied.
    out_ready = 1'b0; in_valid = 1'b1; rand_cmd();
    cycle();
    rand_cmd();
    cycle();
    in_valid = 1'b0;
    chk("prereset_occupancy", 32'(q0.size()), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid_w8", 32'(ov8), 32'd0);
    chk("midrst_out_valid_w16", 32'(ov16), 32'd0);
    chk("midrst_out_valid_w2", 32'(ov2), 32'd0);
    chk("midrst_result_w8", 32'(res8), 32'd0);
    chk("midrst_in_ready_w8", 32'(rdy8), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) cycle();
    log8.delete();
    op = 3'd3; use_acc = 1'b1; a = 16'hFFFF; b = 16'h0000; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("postrst_count", 32'(log8.size()), 32'd1);
    if (log8.size() == 1) chk("postrst_acc_zero", 32'(log8[0]), 32'h4_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
